// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: samples a multiplexed active-low 7-segment bus, decodes each
//   stable digit to BCD and delivers whole NDIG-digit frames on a valid/ready handshake.
// Latency: input change -> shadow capture 2+STABLE_CYC cycles; last capture -> frame_valid 1 cycle.
// Backpressure: frame held on D/ERR/BLK until frame_ready; later frames overwrite shadow and set sticky ovr.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   AN[NDIG], SEG[7]    active-low anode strobes and segment lines (SEG bit0=a .. bit6=g)
//   D[4*NDIG]           captured frame, digit i at D[4i+3:4i]
//   ERR[NDIG], BLK[NDIG] per-digit invalid-pattern / all-off flags
//   frame_valid, frame_ready  frame handshake
//   ovr                 sticky overrun flag
// Build option: define SEG7_HEX_EN to decode the hex letters A..F as valid codes.

module seg7_scan_reader #(
  parameter int NDIG       = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NDIG-1:0]   AN,
  input  logic [6:0]        SEG,
  output logic [4*NDIG-1:0] D,
  output logic [NDIG-1:0]   ERR,
  output logic [NDIG-1:0]   BLK,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              ovr
);

  localparam int         IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [7:0] STABLE_C = 8'(STABLE_CYC);

  typedef enum logic [1:0] {IDLE, TRACK, CAPTURED} state_t;

  // returns {code[3:0], err, blk}
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = {4'h0, 2'b00};
      7'b1111001: decode = {4'h1, 2'b00};
      7'b0100100: decode = {4'h2, 2'b00};
      7'b0110000: decode = {4'h3, 2'b00};
      7'b0011001: decode = {4'h4, 2'b00};
      7'b0010010: decode = {4'h5, 2'b00};
      7'b0000010: decode = {4'h6, 2'b00};
      7'b1111000: decode = {4'h7, 2'b00};
      7'b0000000: decode = {4'h8, 2'b00};
      7'b0011000: decode = {4'h9, 2'b00};
`ifdef SEG7_HEX_EN
      7'b0001000: decode = {4'hA, 2'b00};
      7'b0000011: decode = {4'hB, 2'b00};
      7'b1000110: decode = {4'hC, 2'b00};
      7'b0100001: decode = {4'hD, 2'b00};
      7'b0000110: decode = {4'hE, 2'b00};
      7'b0001110: decode = {4'hF, 2'b00};
`endif
      7'b1111111: decode = {4'hF, 2'b01};
      default:    decode = {4'hF, 2'b10};
    endcase
  endfunction

  // two-flop synchronizers; idle level of the bus is all-ones
  logic [NDIG-1:0] an_s1, an_s2;
  logic [6:0]      seg_s1, seg_s2;
  logic [NDIG+6:0] prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_s1  <= '1;
      an_s2  <= '1;
      seg_s1 <= '1;
      seg_s2 <= '1;
      prev   <= '1;
    end else begin
      an_s1  <= AN;
      an_s2  <= an_s1;
      seg_s1 <= SEG;
      seg_s2 <= seg_s1;
      prev   <= {an_s2, seg_s2};
    end
  end

  logic          onehot;
  logic          same;
  logic [IW-1:0] idx;
  logic [7:0]    cnt, run_cnt;
  logic [5:0]    dec;

  assign onehot = $onehot(~an_s2);
  assign same   = ({an_s2, seg_s2} == prev);
  assign dec    = decode(seg_s2);
  // count this cycle would reach: extend a run of equal samples or restart at 1
  assign run_cnt = !same ? 8'd1 : ((cnt == 8'hFF) ? cnt : cnt + 8'd1);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NDIG; i++)
      if (!an_s2[i]) idx = IW'(i);
  end

  // FSM: state register
  state_t st, st_nxt;
  logic   cap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else       st <= st_nxt;
  end

  // FSM: next state
  always_comb begin
    st_nxt = st;
    if (!onehot)
      st_nxt = IDLE;
    else if (st == CAPTURED && same)
      st_nxt = CAPTURED;
    else
      st_nxt = (run_cnt >= STABLE_C) ? CAPTURED : TRACK;
  end

  // FSM: outputs (capture strobe); CAPTURED never recaptures an unchanged sample
  always_comb begin
    cap = 1'b0;
    if (onehot && !(st == CAPTURED && same) && run_cnt >= STABLE_C)
      cap = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        cnt <= '0;
    else if (!onehot)                 cnt <= '0;
    else if (!(st == CAPTURED && same)) cnt <= run_cnt;
  end

  // shadow frame and seen mask
  logic [3:0]      sh_d [NDIG];
  logic [NDIG-1:0] sh_err, sh_blk;
  logic [NDIG-1:0] seen, cap_mask;
  logic            seen_full, xfer;

  assign cap_mask  = cap ? ({{(NDIG-1){1'b0}}, 1'b1} << idx) : '0;
  assign seen_full = &seen;
  assign xfer      = seen_full && (!frame_valid || frame_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NDIG; i++) sh_d[i] <= '0;
      sh_err <= '0;
      sh_blk <= '0;
    end else if (cap) begin
      sh_d[idx]   <= dec[5:2];
      sh_err[idx] <= dec[1];
      sh_blk[idx] <= dec[0];
    end
  end

  // a capture coinciding with a transfer starts the next frame's mask
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     seen <= '0;
    else if (xfer) seen <= cap_mask;
    else           seen <= seen | cap_mask;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      D           <= '0;
      ERR         <= '0;
      BLK         <= '0;
      frame_valid <= 1'b0;
      ovr         <= 1'b0;
    end else begin
      if (xfer) begin
        for (int i = 0; i < NDIG; i++) D[4*i +: 4] <= sh_d[i];
        ERR         <= sh_err;
        BLK         <= sh_blk;
        frame_valid <= 1'b1;
      end else if (frame_ready) begin
        frame_valid <= 1'b0;
      end
      if (seen_full && frame_valid && !frame_ready)
        ovr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed-vector bench for seg7_scan_reader (NDIG=4, STABLE_CYC=4).
// Latency: n/a.
// Backpressure: drives frame_ready explicitly to exercise hold, accept and overrun.

module tb_seg7_scan_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic [15:0] D;
  logic [3:0]  ERR, BLK;
  logic        frame_valid, frame_ready, ovr;

  int tests = 0;
  int fails = 0;

  seg7_scan_reader #(.NDIG(4), .STABLE_CYC(4)) dut (
    .clk(clk), .reset(reset), .AN(AN), .SEG(SEG), .D(D), .ERR(ERR), .BLK(BLK),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .ovr(ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'b1000000;
      1: pat = 7'b1111001;
      2: pat = 7'b0100100;
      3: pat = 7'b0110000;
      4: pat = 7'b0011001;
      5: pat = 7'b0010010;
      6: pat = 7'b0000010;
      7: pat = 7'b1111000;
      8: pat = 7'b0000000;
      9: pat = 7'b0011000;
      default: pat = 7'b1111111;
    endcase
  endfunction

  // drive one bus state and hold it for n cycles; returns 1 time unit after an edge
  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int n);
    AN  = an;
    SEG = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    show(4'b1110, s0, 8);
    show(4'b1101, s1, 8);
    show(4'b1011, s2, 8);
    show(4'b0111, s3, 8);
  endtask

  task automatic pulse_ready;
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    AN          = 4'hF;
    SEG         = 7'h7F;
    frame_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_D", 32'(D), 32'h0);
    check("rst_ERR", 32'(ERR), 32'h0);
    check("rst_BLK", 32'(BLK), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_ovr", 32'(ovr), 32'h0);
    reset = 1'b0;
    show(4'hF, 7'h7F, 3);

    // basic frame 4,3,2,1 with capture-to-valid latency
    show(4'b1110, pat(1), 8);
    show(4'b1101, pat(2), 8);
    show(4'b1011, pat(3), 8);
    show(4'b0111, pat(4), 6);
    check("lat_fv_low", 32'(frame_valid), 32'h0);
    @(posedge clk); #1;
    check("lat_fv_high", 32'(frame_valid), 32'h1);
    check("f1_D", 32'(D), 32'h4321);
    check("f1_ERR", 32'(ERR), 32'h0);
    check("f1_BLK", 32'(BLK), 32'h0);
    show(4'hF, 7'h7F, 4);
    check("f1_hold", 32'(frame_valid), 32'h1);
    pulse_ready;
    check("f1_accept", 32'(frame_valid), 32'h0);

    // invalid and blank digits
    scan4(pat(5), pat(0), 7'b0000001, 7'b1111111);
    check("eb_fv", 32'(frame_valid), 32'h1);
    check("eb_D", 32'(D), 32'hFF05);
    check("eb_ERR", 32'(ERR), 32'b0100);
    check("eb_BLK", 32'(BLK), 32'b1000);
    pulse_ready;
    check("eb_accept", 32'(frame_valid), 32'h0);

    // digit 0 held only 3 synchronized cycles: must not count as seen
    show(4'b1110, pat(7), 3);
    show(4'hF, 7'h7F, 4);
    show(4'b1101, pat(6), 8);
    show(4'b1011, pat(8), 8);
    show(4'b0111, pat(0), 8);
    check("short_nofr", 32'(frame_valid), 32'h0);
    show(4'b1110, pat(9), 8);
    check("short_fv", 32'(frame_valid), 32'h1);
    check("short_D", 32'(D), 32'h0869);
    pulse_ready;

    // hex letters: A, b, F-letter, blank
    scan4(7'b0001000, 7'b0000011, 7'b0001110, 7'b1111111);
`ifdef SEG7_HEX_EN
    check("hex_D", 32'(D), 32'hFFBA);
    check("hex_ERR", 32'(ERR), 32'b0000);
`else
    check("hex_D", 32'(D), 32'hFFFF);
    check("hex_ERR", 32'(ERR), 32'b0111);
`endif
    check("hex_BLK", 32'(BLK), 32'b1000);
    pulse_ready;
    check("hex_ovr", 32'(ovr), 32'h0);

    // overrun: two frames without ready
    scan4(pat(7), pat(6), pat(5), pat(4));
    check("ov_f1_D", 32'(D), 32'h4567);
    check("ov_f1_ovr", 32'(ovr), 32'h0);
    scan4(pat(3), pat(2), pat(1), pat(0));
    check("ov_hold_D", 32'(D), 32'h4567);
    check("ov_fv", 32'(frame_valid), 32'h1);
    check("ov_ovr", 32'(ovr), 32'h1);
    pulse_ready;
    check("ov_load_D", 32'(D), 32'h0123);
    check("ov_load_fv", 32'(frame_valid), 32'h1);

    // async reset mid-capture, between clock edges
    show(4'b1110, pat(5), 3);
    #2;
    reset = 1'b1;
    #1;
    check("mid_D", 32'(D), 32'h0);
    check("mid_fv", 32'(frame_valid), 32'h0);
    check("mid_ovr", 32'(ovr), 32'h0);
    check("mid_ERR_BLK", 32'({ERR, BLK}), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    show(4'hF, 7'h7F, 3);

    // restart from IDLE after reset
    scan4(pat(1), pat(2), pat(3), pat(4));
    check("post_D", 32'(D), 32'h4321);
    check("post_fv", 32'(frame_valid), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
